// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, free-run/single-step advance,
// all-zero lock-up recovery, period measurement and active-low hex digits.
module lfsr_gen #(
   parameter int               WIDTH  = 16,
   parameter logic [WIDTH-1:0] TAPS   = 16'hD008,
   parameter logic [WIDTH-1:0] SEED   = 16'h0001,
   parameter int               DIGITS = (WIDTH + 3) / 4
) (
   input  logic                  i_clock,
   input  logic                  i_resetn,
   input  logic                  i_enable,
   input  logic                  i_mode,
   input  logic                  i_step,
   input  logic                  i_load,
   input  logic [WIDTH-1:0]      i_seed_in,
   output logic [WIDTH-1:0]      o_q,
   output logic [WIDTH-1:0]      o_period,
   output logic                  o_period_valid,
   output logic                  o_wrap,
   output logic                  o_lockup,
   output logic [7*DIGITS-1:0]   o_hex_out
);

   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   // Active-low segment pattern, bit order g..a
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [WIDTH-1:0]    r_q;
   logic [WIDTH-1:0]    r_start;
   logic [WIDTH-1:0]    r_count;
   logic [WIDTH-1:0]    r_period;
   logic                r_period_valid;
   logic                r_wrap;
   logic                r_lockup;
   logic                r_step_d;

   logic                w_fb;
   logic [WIDTH-1:0]    w_next;
   logic                w_step_rise;
   logic                w_advance;
   logic [4*DIGITS-1:0] w_q_pad;

   assign w_fb        = ^(r_q & TAPS);
   assign w_next      = {r_q[WIDTH-2:0], w_fb};
   assign w_step_rise = i_step & ~r_step_d;
   assign w_advance   = i_enable & (i_mode ? w_step_rise : 1'b1);

   // State, period measurement and event pulses; reset > load > advance > hold
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_q            <= SEED;
         r_start        <= SEED;
         r_count        <= ZERO;
         r_period       <= ZERO;
         r_period_valid <= 1'b0;
         r_wrap         <= 1'b0;
         r_lockup       <= 1'b0;
         r_step_d       <= 1'b0;
      end else begin
         r_step_d <= i_step;
         r_wrap   <= 1'b0;
         r_lockup <= 1'b0;
         if (i_load) begin
            r_count <= ZERO;
            if (i_seed_in != ZERO) begin
               r_q     <= i_seed_in;
               r_start <= i_seed_in;
            end else begin
               // an all-zero state would lock the register up forever
               r_q      <= SEED;
               r_start  <= SEED;
               r_lockup <= 1'b1;
            end
         end else if (w_advance) begin
            r_q <= w_next;
            if (w_next == r_start) begin
               r_period       <= r_count + ONE;
               r_period_valid <= 1'b1;
               r_wrap         <= 1'b1;
               r_count        <= ZERO;
            end else begin
               r_count <= r_count + ONE;
            end
         end else begin
            r_q <= r_q;
         end
      end
   end

   // Zero-pad the state to whole nibbles and decode each digit
   always_comb begin
      w_q_pad              = '0;
      w_q_pad[WIDTH-1:0]   = r_q;
      o_hex_out            = '0;
      for (int k = 0; k < DIGITS; k++) begin
         o_hex_out[7*k +: 7] = seg7(w_q_pad[4*k +: 4]);
      end
   end

   assign o_q            = r_q;
   assign o_period       = r_period;
   assign o_period_valid = r_period_valid;
   assign o_wrap         = r_wrap;
   assign o_lockup       = r_lockup;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a 4-bit instance for sequence/load/step/priority
// behaviour and a default 16-bit instance for the full-period measurement.
module tb_lfsr_gen;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // 4-bit instance signals
   logic       resetn, enable, mode, step, load;
   logic [3:0] seed_in;
   logic [3:0] q4, period4;
   logic       valid4, wrap4, lock4;
   logic [6:0] hex4;

   // 16-bit instance signals
   logic        resetn16, load16;
   logic [15:0] seed16;
   logic [15:0] q16, period16;
   logic        valid16, wrap16, lock16;
   logic [27:0] hex16;

   int n_vec = 0;
   int n_err = 0;

   lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h1)) dut4 (
      .i_clock(clk), .i_resetn(resetn), .i_enable(enable), .i_mode(mode),
      .i_step(step), .i_load(load), .i_seed_in(seed_in),
      .o_q(q4), .o_period(period4), .o_period_valid(valid4),
      .o_wrap(wrap4), .o_lockup(lock4), .o_hex_out(hex4));

   lfsr_gen dut16 (
      .i_clock(clk), .i_resetn(resetn16), .i_enable(1'b1), .i_mode(1'b0),
      .i_step(1'b0), .i_load(load16), .i_seed_in(seed16),
      .o_q(q16), .o_period(period16), .o_period_valid(valid16),
      .o_wrap(wrap16), .o_lockup(lock16), .o_hex_out(hex16));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [3:0] seq [15];
   int         cyc;
   bit         seen;

   initial begin
      seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
              4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
      resetn = 1'b0; enable = 1'b1; mode = 1'b0; step = 1'b0; load = 1'b0;
      seed_in = 4'h0;
      resetn16 = 1'b0; load16 = 1'b0; seed16 = 16'h0000;

      // reset state
      tick(); tick();
      chk("rst_q", q4, 4'h1);
      chk("rst_period", period4, 4'h0);
      chk("rst_valid", valid4, 1'b0);
      chk("rst_wrap", wrap4, 1'b0);
      chk("rst_lockup", lock4, 1'b0);
      chk("rst_hex4", hex4, 7'b1111001);
      chk("rst_hex16", hex16, 28'b1000000_1000000_1000000_1111001);

      // free-run sequence from reset release
      resetn = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk($sformatf("seq_q%0d", i), q4, seq[i % 15]);
         chk($sformatf("seq_wrap%0d", i), wrap4, (i == 15) ? 1'b1 : 1'b0);
      end
      chk("seq_period", period4, 4'hF);
      chk("seq_valid", valid4, 1'b1);
      tick();
      chk("seq_wrap_clear", wrap4, 1'b0);
      chk("seq_q_after", q4, 4'h2);

      // load nonzero seed, full cycle from it
      load = 1'b1; seed_in = 4'h9;
      tick();
      load = 1'b0;
      chk("load_q", q4, 4'h9);
      chk("load_hex", hex4, 7'b0010000);
      chk("load_lock", lock4, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk($sformatf("ld_q%0d", i), q4, seq[(3 + i) % 15]);
         chk($sformatf("ld_wrap%0d", i), wrap4, (i == 15) ? 1'b1 : 1'b0);
      end
      chk("ld_period", period4, 4'hF);

      // all-zero load is replaced by SEED
      load = 1'b1; seed_in = 4'h0;
      tick();
      load = 1'b0; enable = 1'b0;
      chk("zero_q", q4, 4'h1);
      chk("zero_lock", lock4, 1'b1);
      tick();
      chk("zero_lock_clear", lock4, 1'b0);
      chk("zero_q_hold", q4, 4'h1);

      // single-step: long high, low, high => two advances
      enable = 1'b1; mode = 1'b1; step = 1'b0;
      tick();
      chk("ss_idle", q4, 4'h1);
      step = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("ss_held", q4, 4'h2);
      step = 1'b0;
      tick();
      chk("ss_low", q4, 4'h2);
      step = 1'b1;
      tick();
      chk("ss_second", q4, 4'h4);
      step = 1'b0;
      tick();

      // steps while disabled are lost
      enable = 1'b0; step = 1'b1;
      tick();
      chk("dis_step1", q4, 4'h4);
      step = 1'b0; tick();
      step = 1'b1; tick();
      enable = 1'b1;
      tick();
      chk("dis_step_lost", q4, 4'h4);

      // mode 0->1 with step already high: no advance
      mode = 1'b0;
      tick();
      chk("fr_adv", q4, 4'h9);
      mode = 1'b1;
      tick();
      chk("mode_sw_hold", q4, 4'h9);
      step = 1'b0;
      tick();

      // load beats coincident step edge
      step = 1'b1; load = 1'b1; seed_in = 4'h5;
      tick();
      load = 1'b0;
      chk("prio_q", q4, 4'h5);
      tick();
      chk("prio_q_hold", q4, 4'h5);
      chk("prio_valid_kept", valid4, 1'b1);
      step = 1'b0;

      // reset mid-sequence restores everything
      resetn = 1'b0;
      tick();
      chk("mid_rst_q", q4, 4'h1);
      chk("mid_rst_period", period4, 4'h0);
      chk("mid_rst_valid", valid4, 1'b0);
      chk("mid_rst_wrap", wrap4, 1'b0);
      resetn = 1'b1; step = 1'b1;
      tick();
      chk("post_rst_step", q4, 4'h2);
      step = 1'b0;

      // 16-bit default: full maximal period
      resetn16 = 1'b1;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 70000) begin
         tick();
         cyc++;
         if (wrap16) seen = 1'b1;
      end
      chk("w16_cycles", cyc, 65535);
      chk("w16_period", period16, 16'hFFFF);
      chk("w16_valid", valid16, 1'b1);
      chk("w16_q", q16, 16'h0001);
      chk("w16_lock", lock16, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised Fibonacci LFSR pattern generator with seed load, free-run/single-step modes, all-zero lock-up protection, and automatic period measurement. Each nibble of the state drives one active-low 7-segment digit. It replaces the fixed 4-bit, button-clocked LFSR in board-level labs and serves as a reusable pseudo-random source for later datapaths.

## Interface

- WIDTH, 16, LFSR length in bits; legal range 3..32.
- TAPS, 16'hD008, feedback mask; bit i = 1 puts q[i] in the XOR. Default is x^16+x^15+x^13+x^4+1.
- SEED, 16'h0001, reset and lock-up recovery state; must be nonzero.
- DIGITS, (WIDTH+3)/4, number of hex digits driven.
- Clock  in  1  single system clock; all state updates on its rising edge.
- Resetn  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- enable  in  1  gates all advances.
- mode  in  1  0 = free-run (advance every enabled cycle); 1 = single-step (advance on rising edge of step).
- step  in  1  step request; level input, edge-detected internally.
- load  in  1  load seed_in on the next edge.
- seed_in  in  WIDTH  state to load.
- q  out  WIDTH  current LFSR state.
- period  out  WIDTH  last measured sequence length.
- period_valid  out  1  high once at least one period has been measured.
- wrap  out  1  one-cycle pulse when the state returns to the start state.
- lockup  out  1  one-cycle pulse when an all-zero load is replaced by SEED.
- hex_out  out  7*DIGITS  segments; digit k occupies bits [7k+6:7k].

## Operation

- Feedback: fb = XOR over i of (q[i] & TAPS[i]). Next state = {q[WIDTH-2:0], fb}.
- Internal registers:
  - step_d: previous value of step.
  - start: state at the last reset or load.
  - count: advances since start, WIDTH bits.
- step_rise = step & ~step_d. step_d updates every cycle, including while enable = 0.
- Advance condition: enable & (mode ? step_rise : 1).
- Priority per edge: Resetn low > load > advance > hold.
- Load:
  - If seed_in != 0: q <= seed_in, start <= seed_in.
  - If seed_in == 0: q <= SEED, start <= SEED, lockup <= 1.
  - In both cases count <= 0. A coincident advance or step edge is discarded.
- Advance:
  - q <= next state.
  - If next state == start: period <= count+1, period_valid <= 1, wrap <= 1, count <= 0.
  - Otherwise: count <= count+1, wrap <= 0.
- count wraps modulo 2^WIDTH. This only matters for non-maximal TAPS whose cycle excludes start; period is then never updated.
- wrap and lockup are 0 on every edge where their set condition is absent.
- load does not clear period or period_valid; they hold the last measurement.
- hex_out is combinational from q:
  - Digit k shows nibble q[4k+3:4k], zero-padded above WIDTH.
  - Active-low, bit order g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- q is never all-zero.

## Timing

- Reset values: q=SEED, start=SEED, count=0, period=0, period_valid=0, wrap=0, lockup=0, step_d=0.
- Resetn low mid-sequence: all of the above restored on that edge; in-flight step edges are lost.
- Latency:
  - q updates on the edge where the advance condition holds.
  - wrap, lockup, period, and period_valid are registered and change on the same edge as q.
  - hex_out follows q combinationally, with zero cycles of added latency.
- Single-step: one advance per low-to-high transition of step, however long step is held.
  - A step rising while enable = 0 is lost.
  - A step rising one cycle after reset deassertion counts, provided step was low during reset.
- mode changes take effect on the next edge. Switching 0→1 while step is already high does not advance.

## Test plan

- Basic sequence, reset release: WIDTH=4, TAPS=4'b1100, SEED=1, mode=0, enable=1. Required q over 15 edges: 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8. On the 15th edge, q=1, wrap pulses, period=15, period_valid=1.
- Default configuration (WIDTH=16): free-run 65535 cycles → wrap once, period=16'hFFFF; hex_out digit 0 = 1111001 at reset.
- Load and lock-up:
  - Load seed_in=4'h9 → q=9, count restarts; 15 advances later, wrap with period=15.
  - Load seed_in=0 → q=1, lockup high for exactly one cycle.
- Single-step: mode=1, step held high 10 cycles, then low, then high → exactly 2 advances. Steps arriving with enable=0 → no change.
- Priority: load and a step edge on the same cycle → only the load takes effect. Resetn low during the sequence with period_valid=1 → all outputs return to reset values on the next edge.
